// File: rtl/mmio_gpi_debounce.sv
// mmio_gpi_debounce: MMIO input slot with per-bit debounce, W1C edge latches and masked level irq
module mmio_gpi_debounce #(
    parameter int W        = 32,
    parameter int TICK_DIV = 100000,
    parameter int DB_TICKS = 20
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cs,
    input  logic          write,
    input  logic          read,
    input  logic [4:0]    addr,
    input  logic [31:0]   write_data,
    output logic [31:0]   read_data,
    input  logic [W-1:0]  d_in,
    output logic          irq
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(DB_TICKS + 1);
    logic [PW-1:0] pcnt;
    logic          tick, wr, unused_ok;
    logic [W-1:0]  s1, sync, db, db_q, rise, fall, mask, clr_rise, clr_fall, rd;
    logic [CW-1:0] cnt [W];
    // reads carry no side effects, so the strobe and the upper write bits are simply dropped
    assign unused_ok = &{1'b0, read, write_data};
    assign tick      = pcnt == PW'(TICK_DIV - 1);
    assign wr        = cs & write;
    assign clr_rise  = wr && addr == 5'd2 ? write_data[W-1:0] : '0;
    assign clr_fall  = wr && addr == 5'd3 ? write_data[W-1:0] : '0;
    assign irq       = |((rise | fall) & mask);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pcnt <= '0;
            s1   <= '0;
            sync <= '0;
            db   <= '0;
            db_q <= '0;
            rise <= '0;
            fall <= '0;
            mask <= '0;
            for (int i = 0; i < W; i++) cnt[i] <= '0;
        end else begin
            s1   <= d_in;
            sync <= s1;
            pcnt <= tick ? '0 : pcnt + 1'b1;
            db_q <= db;
            // a new edge in the same cycle as its W1C clear keeps the bit set
            rise <= (rise & ~clr_rise) | (db & ~db_q);
            fall <= (fall & ~clr_fall) | (~db & db_q);
            if (wr && addr == 5'd4) mask <= write_data[W-1:0];
            if (tick) begin
                for (int i = 0; i < W; i++) begin
                    if (sync[i] == db[i]) cnt[i] <= '0;
                    else if (cnt[i] == CW'(DB_TICKS - 1)) begin
                        db[i]  <= sync[i];
                        cnt[i] <= '0;
                    end else cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end
    always_comb begin
        rd = addr == 5'd0 ? sync :
             addr == 5'd1 ? db   :
             addr == 5'd2 ? rise :
             addr == 5'd3 ? fall :
             addr == 5'd4 ? mask : '0;
        read_data = 32'(rd);
    end
endmodule

// File: tb/tb_mmio_gpi_debounce.sv
// tb_mmio_gpi_debounce: scoreboard bench; reads queue expected {irq,read_data} from a behavioural model
module tb_mmio_gpi_debounce;
    localparam int W = 8;
    localparam int TDIV = 4;
    localparam int DBT = 3;
    logic          clk = 0, reset_n = 0, cs = 0, write = 0, read = 0;
    logic [4:0]    addr = 0;
    logic [31:0]   write_data = 0, read_data;
    logic [W-1:0]  d_in = 0;
    logic          irq;
    int            n_checks = 0, n_pass = 0;

    mmio_gpi_debounce #(.W(W), .TICK_DIV(TDIV), .DB_TICKS(DBT)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .write(write), .read(read), .addr(addr),
        .write_data(write_data), .read_data(read_data), .d_in(d_in), .irq(irq)
    );

    always #5 clk = ~clk;

    // behavioural model: the debounced level flips after DBT consecutive disagreeing samples
    int           cyc;
    int           run [W];
    logic [W-1:0] m_s1, m_sync, m_db, m_dbq, m_rise, m_fall, m_mask;

    task automatic model_step();
        logic [W-1:0] nr, nf;
        if (!reset_n) begin
            cyc = 0; m_s1 = 0; m_sync = 0; m_db = 0; m_dbq = 0;
            m_rise = 0; m_fall = 0; m_mask = 0;
            for (int i = 0; i < W; i++) run[i] = 0;
            return;
        end
        nr = m_rise | (m_db & ~m_dbq);
        nf = m_fall | (~m_db & m_dbq);
        if (cs && write && addr == 2) nr = (m_rise & ~write_data[W-1:0]) | (m_db & ~m_dbq);
        if (cs && write && addr == 3) nf = (m_fall & ~write_data[W-1:0]) | (~m_db & m_dbq);
        if (cs && write && addr == 4) m_mask = write_data[W-1:0];
        m_rise = nr;
        m_fall = nf;
        m_dbq = m_db;
        if (cyc % TDIV == TDIV - 1)
            for (int i = 0; i < W; i++) begin
                run[i] = (m_sync[i] != m_db[i]) ? run[i] + 1 : 0;
                if (run[i] == DBT) begin
                    m_db[i] = m_sync[i];
                    run[i] = 0;
                end
            end
        m_sync = m_s1;
        m_s1 = d_in;
        cyc++;
    endtask

    initial forever begin
        @(posedge clk or negedge reset_n);
        model_step();
    end

    function automatic logic [32:0] expect_of(input logic [4:0] a);
        logic [W-1:0] v;
        v = a == 0 ? m_sync : a == 1 ? m_db : a == 2 ? m_rise : a == 3 ? m_fall : a == 4 ? m_mask : '0;
        return {|((m_rise | m_fall) & m_mask), 32'(v)};
    endfunction

    typedef struct { logic [4:0] a; logic [32:0] e; } exp_t;
    exp_t sb[$];

    // monitor: every read strobe is an output to be matched against the queue head
    initial forever begin
        exp_t x;
        @(negedge clk);
        #1;
        if (read && reset_n) begin
            n_checks++;
            if (sb.size() == 0) $display("FAIL read addr=%0d: no expected entry queued", addr);
            else begin
                x = sb.pop_front();
                if ({irq, read_data} === x.e) n_pass++;
                else $display("FAIL read addr=%0d got irq=%b data=%h expected irq=%b data=%h",
                              x.a, irq, read_data, x.e[32], x.e[31:0]);
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        cs = 0; write = 0; read = 0;
    endtask

    task automatic do_read(input logic [4:0] a);
        @(negedge clk);
        cs = 1; write = 0; read = 1; addr = a;
        sb.push_back('{a, expect_of(a)});
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d, input logic sel);
        @(negedge clk);
        cs = sel; write = 1; read = 0; addr = a; write_data = d;
    endtask

    task automatic read_all();
        for (int a = 0; a < 5; a++) do_read(5'(a));
        do_read(5'd9);
    endtask

    task automatic poll(input logic [4:0] a, input int n);
        for (int i = 0; i < n; i++) do_read(a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        cs = 0; write = 0; read = 0; reset_n = 0;
        @(negedge clk);
        reset_n = 1;
    endtask

    initial begin
        logic hit;
        repeat (3) @(negedge clk);
        reset_n = 1;
        read_all();
        // clean rising input, observed every cycle through debounce and irq
        do_write(5'd4, 32'h1, 1);
        d_in[0] = 1;
        poll(5'd1, 20);
        do_read(5'd2);
        // short glitch on bit1 never reaches db
        d_in[1] = 1;
        poll(5'd1, 8);
        d_in[1] = 0;
        poll(5'd2, 10);
        poll(5'd3, 10);
        // W1C clear drops irq
        do_write(5'd2, 32'h1, 1);
        do_read(5'd2);
        // set wins over a simultaneous clear
        d_in[0] = 0;
        poll(5'd3, 20);
        d_in[0] = 1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            @(negedge clk);
            cs = 0; write = 0; read = 0;
            if (m_db[0] && !m_dbq[0]) begin
                cs = 1; write = 1; addr = 2; write_data = 32'h1; hit = 1;
            end
        end
        n_checks++;
        if (hit) n_pass++;
        else $display("FAIL set_wins_window got no rise edge within 40 clk, required one");
        do_read(5'd2);
        // release, fall latch, writes that must not matter
        d_in[0] = 0;
        poll(5'd3, 20);
        do_write(5'd3, 32'h2, 1);
        do_read(5'd3);
        do_write(5'd0, 32'hFF, 1);
        do_write(5'd1, 32'hFF, 1);
        do_write(5'd4, 32'hFFFF_FF00, 0);
        read_all();
        // reset in the middle of a debounce count
        d_in[2] = 1;
        hit = 0;
        for (int i = 0; i < 40 && !hit; i++) begin
            idle();
            hit = run[2] == 2;
        end
        do_reset();
        read_all();
        poll(5'd1, 20);
        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            int r;
            if ($urandom_range(0, 24) == 0) d_in[$urandom_range(0, W - 1)] ^= 1'b1;
            r = $urandom_range(0, 99);
            if (r < 55) do_read(5'($urandom_range(0, 7) == 0 ? $urandom_range(5, 31) : $urandom_range(0, 4)));
            else if (r < 72) do_write(5'($urandom_range(0, 5)), $urandom, $urandom_range(0, 5) != 0);
            else if (r == 72 && i > 700 && i < 720) do_reset();
            else idle();
        end
        idle();
        idle();
        n_checks++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL scoreboard_drain got %0d pending entries, required 0", sb.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
